demux_1_to_2: RTL and testbench

DEMUX_1_TO_2 -- requirements
Module: demux_1_to_2

---
 rtl/mips_accel_pkg.sv | 7 +
 rtl/demux_out_buf.sv | 57 +++++
 rtl/demux_1_to_2.sv | 83 ++++++++
 tb/tb_demux_1_to_2.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/mips_accel_pkg.sv
// Shared constants for the MIPS accelerator datapath blocks.
package mips_accel_pkg;
  localparam int WORD_W    = 32;
  localparam int BUF_DEPTH = 2;
  localparam int CNT_W     = 16;
  localparam int OCC_W     = $clog2(BUF_DEPTH + 1);
endpackage

// File: rtl/demux_out_buf.sv
// Two-entry circular output buffer; push visible on head after one edge.
// Pushes while full and pops while empty are ignored; head reads 0 when empty.
module demux_out_buf
  import mips_accel_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [OCC_W-1:0] count,
  output logic             head_vld,
  output logic [WIDTH-1:0] head_data
);

  localparam logic [OCC_W-1:0] FULL = OCC_W'(BUF_DEPTH);

  logic [WIDTH-1:0] mem [BUF_DEPTH];
  logic             wr_ptr;
  logic             rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && (count < FULL);
  assign do_pop  = pop && (count != '0);

  // Depth is two, so a 1-bit pointer toggle is the 1 -> 0 wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head_vld  = (count != '0);
  assign head_data = head_vld ? mem[rd_ptr] : '0;

endmodule

// File: rtl/demux_1_to_2.sv
// 1-to-2 demux with 2-deep per-port buffers, 1-cycle latency; IN_READY stalls on the
// selected buffer's occupancy only. Optional transfer counters under DEMUX_STATS_EN.
module demux_1_to_2
  import mips_accel_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int DEPTH = BUF_DEPTH
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic             IN_SEL,
  input  logic [WIDTH-1:0] IN_DATA,
  output logic             A_VALID,
  input  logic             A_READY,
  output logic [WIDTH-1:0] A_DATA,
  output logic             B_VALID,
  input  logic             B_READY,
  output logic [WIDTH-1:0] B_DATA
`ifdef DEMUX_STATS_EN
  ,
  output logic [CNT_W-1:0] CNT_A,
  output logic [CNT_W-1:0] CNT_B
`endif
);

  if (DEPTH != BUF_DEPTH) begin : g_bad_depth
    $error("demux_1_to_2 supports only DEPTH == 2");
  end

  localparam logic [OCC_W-1:0] FULL = OCC_W'(BUF_DEPTH);

  logic [OCC_W-1:0] cnt_a;
  logic [OCC_W-1:0] cnt_b;
  logic             push_a;
  logic             push_b;
  logic             pop_a;
  logic             pop_b;

  // No pop credit: a full buffer refuses even if its consumer drains this edge.
  assign IN_READY = IN_SEL ? (cnt_b < FULL) : (cnt_a < FULL);

  assign push_a = IN_VALID && IN_READY && !IN_SEL;
  assign push_b = IN_VALID && IN_READY && IN_SEL;
  assign pop_a  = A_VALID && A_READY;
  assign pop_b  = B_VALID && B_READY;

  demux_out_buf #(.WIDTH(WIDTH)) u_buf_a (
    .clk       (CLK),
    .rst       (RST),
    .push      (push_a),
    .push_data (IN_DATA),
    .pop       (pop_a),
    .count     (cnt_a),
    .head_vld  (A_VALID),
    .head_data (A_DATA)
  );

  demux_out_buf #(.WIDTH(WIDTH)) u_buf_b (
    .clk       (CLK),
    .rst       (RST),
    .push      (push_b),
    .push_data (IN_DATA),
    .pop       (pop_b),
    .count     (cnt_b),
    .head_vld  (B_VALID),
    .head_data (B_DATA)
  );

`ifdef DEMUX_STATS_EN
  always_ff @(posedge CLK) begin
    if (RST) begin
      CNT_A <= '0;
      CNT_B <= '0;
    end else begin
      if (push_a) CNT_A <= CNT_A + 1'b1;
      if (push_b) CNT_B <= CNT_B + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_demux_1_to_2.sv
// Bench for demux_1_to_2: directed vector table, then queue-model random traffic.
module tb_demux_1_to_2;

  logic        CLK;
  logic        RST;
  logic        IN_VALID;
  logic        IN_READY;
  logic        IN_SEL;
  logic [31:0] IN_DATA;
  logic        A_VALID;
  logic        A_READY;
  logic [31:0] A_DATA;
  logic        B_VALID;
  logic        B_READY;
  logic [31:0] B_DATA;
`ifdef DEMUX_STATS_EN
  logic [15:0] CNT_A;
  logic [15:0] CNT_B;
`endif

  demux_1_to_2 #(.WIDTH(32), .DEPTH(2)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .IN_VALID (IN_VALID),
    .IN_READY (IN_READY),
    .IN_SEL   (IN_SEL),
    .IN_DATA  (IN_DATA),
    .A_VALID  (A_VALID),
    .A_READY  (A_READY),
    .A_DATA   (A_DATA),
    .B_VALID  (B_VALID),
    .B_READY  (B_READY),
    .B_DATA   (B_DATA)
`ifdef DEMUX_STATS_EN
    ,
    .CNT_A    (CNT_A),
    .CNT_B    (CNT_B)
`endif
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  int checks = 0;
  int errors = 0;
  int xfers  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst, v, sel;
    logic [31:0] d;
    logic        ar, br;
    logic        chk_rdy, rdy;
    logic        av;
    logic [31:0] ad;
    logic        bv;
    logic [31:0] bd;
  } vec_t;

  vec_t tbl[17];

  task automatic drive(input logic r, v, s, input logic [31:0] d, input logic ar, br);
    RST = r; IN_VALID = v; IN_SEL = s; IN_DATA = d; A_READY = ar; B_READY = br;
  endtask

  // Reference: each port is an order-preserving queue of at most two words.
  logic [31:0] qa[$];
  logic [31:0] qb[$];

  task automatic mcycle(input logic r, v, s, input logic [31:0] d, input logic ar, br);
    logic rdy_m;
    @(negedge CLK);
    drive(r, v, s, d, ar, br);
    #1;
    rdy_m = ((s ? qb.size() : qa.size()) < 2);
    chk("m_in_ready", IN_READY, rdy_m);
    chk("m_a_valid", A_VALID, qa.size() != 0);
    chk("m_a_data", A_DATA, (qa.size() != 0) ? qa[0] : 32'h0);
    chk("m_b_valid", B_VALID, qb.size() != 0);
    chk("m_b_data", B_DATA, (qb.size() != 0) ? qb[0] : 32'h0);
    if (IN_VALID && IN_READY && !RST) xfers++;
    @(posedge CLK);
    if (r) begin
      qa.delete();
      qb.delete();
    end else begin
      if (ar && qa.size() != 0) void'(qa.pop_front());
      if (br && qb.size() != 0) void'(qb.pop_front());
      if (v && rdy_m) begin
        if (s) qb.push_back(d);
        else   qa.push_back(d);
      end
    end
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);

    //            rst  v    sel  data          ar   br   chk  rdy  av   a_data        bv   b_data
    tbl[0]  = '{1'b1,1'b0,1'b0,32'h0,        1'b0,1'b0,1'b0,1'b0,1'b0,32'h0,        1'b0,32'h0};
    tbl[1]  = '{1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0,1'b1,1'b1,1'b0,32'h0,        1'b0,32'h0};
    tbl[2]  = '{1'b0,1'b1,1'b0,32'h11111111, 1'b1,1'b0,1'b1,1'b1,1'b1,32'h11111111, 1'b0,32'h0};
    tbl[3]  = '{1'b0,1'b0,1'b0,32'h0,        1'b1,1'b0,1'b1,1'b1,1'b0,32'h0,        1'b0,32'h0};
    tbl[4]  = '{1'b0,1'b1,1'b0,32'hA0000001, 1'b0,1'b0,1'b1,1'b1,1'b1,32'hA0000001, 1'b0,32'h0};
    tbl[5]  = '{1'b0,1'b1,1'b0,32'hA0000002, 1'b0,1'b0,1'b1,1'b1,1'b1,32'hA0000001, 1'b0,32'h0};
    tbl[6]  = '{1'b0,1'b1,1'b0,32'hA0000003, 1'b0,1'b0,1'b1,1'b0,1'b1,32'hA0000001, 1'b0,32'h0};
    tbl[7]  = '{1'b0,1'b1,1'b1,32'hB0000001, 1'b0,1'b0,1'b1,1'b1,1'b1,32'hA0000001, 1'b1,32'hB0000001};
    tbl[8]  = '{1'b0,1'b0,1'b0,32'h0,        1'b1,1'b0,1'b1,1'b0,1'b1,32'hA0000002, 1'b1,32'hB0000001};
    tbl[9]  = '{1'b0,1'b0,1'b0,32'h0,        1'b1,1'b0,1'b1,1'b1,1'b0,32'h0,        1'b1,32'hB0000001};
    tbl[10] = '{1'b0,1'b1,1'b1,32'hB0000002, 1'b0,1'b1,1'b1,1'b1,1'b0,32'h0,        1'b1,32'hB0000002};
    tbl[11] = '{1'b0,1'b1,1'b1,32'hB0000003, 1'b0,1'b0,1'b1,1'b1,1'b0,32'h0,        1'b1,32'hB0000002};
    tbl[12] = '{1'b0,1'b1,1'b1,32'hB0000004, 1'b0,1'b1,1'b1,1'b0,1'b0,32'h0,        1'b1,32'hB0000003};
    tbl[13] = '{1'b0,1'b1,1'b0,32'hA0000004, 1'b0,1'b0,1'b1,1'b1,1'b1,32'hA0000004, 1'b1,32'hB0000003};
    tbl[14] = '{1'b1,1'b1,1'b0,32'hA0000005, 1'b0,1'b0,1'b1,1'b1,1'b0,32'h0,        1'b0,32'h0};
    tbl[15] = '{1'b0,1'b0,1'b0,32'h0,        1'b0,1'b0,1'b1,1'b1,1'b0,32'h0,        1'b0,32'h0};
    tbl[16] = '{1'b0,1'b1,1'b1,32'hB0000005, 1'b0,1'b0,1'b1,1'b1,1'b0,32'h0,        1'b1,32'hB0000005};

    for (int i = 0; i < 17; i++) begin
      @(negedge CLK);
      drive(tbl[i].rst, tbl[i].v, tbl[i].sel, tbl[i].d, tbl[i].ar, tbl[i].br);
      #1;
      if (tbl[i].chk_rdy) chk($sformatf("v%0d_in_ready", i), IN_READY, tbl[i].rdy);
      @(posedge CLK);
      #1;
      chk($sformatf("v%0d_a_valid", i), A_VALID, tbl[i].av);
      chk($sformatf("v%0d_a_data", i), A_DATA, tbl[i].ad);
      chk($sformatf("v%0d_b_valid", i), B_VALID, tbl[i].bv);
      chk($sformatf("v%0d_b_data", i), B_DATA, tbl[i].bd);
    end

    // Resynchronise the model with an empty DUT.
    @(negedge CLK);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    @(posedge CLK);
    qa.delete();
    qb.delete();

    // Full-rate alternating traffic with both consumers always ready.
    xfers = 0;
    for (int i = 0; i < 100; i++) begin
      mcycle(1'b0, 1'b1, i[0], $urandom, 1'b1, 1'b1);
    end
    chk("throughput_xfers", xfers, 100);

    // Random traffic with occasional reset pulses.
    for (int i = 0; i < 600; i++) begin
      mcycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0), $urandom_range(0, 1),
             $urandom, $urandom_range(0, 1), $urandom_range(0, 1));
    end
    mcycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    mcycle(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);

`ifdef DEMUX_STATS_EN
    mcycle(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    for (int i = 0; i < 65537; i++) begin
      mcycle(1'b0, 1'b1, 1'b0, i, 1'b1, 1'b0);
    end
    @(negedge CLK);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    #1;
    chk("cnt_a_wrap", CNT_A, 32'h1);
    chk("cnt_b_zero", CNT_B, 32'h0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
